imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: assembles little-endian bytes into
// 32-bit words and issues one write strobe per completed word.
module imem_loader #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [31:0]         asm_q, asm_d;
    logic                overflow_q, overflow_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [31:0]         merged;
    logic                hs;

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_addr_d  = word_addr_q;
        word_count_d = word_count_q;
        asm_d        = asm_q;
        overflow_d   = overflow_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        in_ready = (state_q == LOAD);
        busy     = (state_q == LOAD);
        done     = (state_q == DONE);
        hs       = in_ready && in_valid;

        // asm_q is cleared on every completed word and on start, so bytes
        // above the current index are already zero in the merged word.
        merged = asm_q;
        merged[{byte_idx_q, 3'b000} +: 8] = in_data;

        if (start) begin
            state_d      = LOAD;
            byte_idx_d   = '0;
            word_addr_d  = '0;
            word_count_d = '0;
            asm_d        = '0;
            overflow_d   = 1'b0;
        end else if (hs) begin
            if (byte_idx_q == 2'd3 || in_last) begin
                wr_en_d    = 1'b1;
                wr_addr_d  = word_addr_q;
                wr_data_d  = merged;
                asm_d      = '0;
                byte_idx_d = '0;
                if (word_count_q != COUNT_MAX) begin
                    word_count_d = word_count_q + 1'b1;
                end
                if (word_addr_q != ADDR_MAX) begin
                    word_addr_d = word_addr_q + 1'b1;
                end
                if (in_last) begin
                    state_d = DONE;
                end else if (word_addr_q == ADDR_MAX) begin
                    state_d    = DONE;
                    overflow_d = 1'b1;
                end
            end else begin
                asm_d      = merged;
                byte_idx_d = byte_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            word_addr_q  <= '0;
            word_count_q <= '0;
            asm_q        <= '0;
            overflow_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_addr_q  <= word_addr_d;
            word_count_q <= word_count_d;
            asm_q        <= asm_d;
            overflow_q   <= overflow_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance plus a 4-word
// instance sharing the same stimulus for the capacity-overflow case.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last;
    logic [7:0]  in_data;

    logic        in_ready, wr_en, busy, done, overflow;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [12:0] word_count;

    logic        in_ready_s, wr_en_s, busy_s, done_s, overflow_s;
    logic [1:0]  wr_addr_s;
    logic [31:0] wr_data_s;
    logic [2:0]  word_count_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .overflow(overflow), .word_count(word_count)
    );

    imem_loader #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready_s),
        .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s), .busy(busy_s),
        .done(done_s), .overflow(overflow_s), .word_count(word_count_s)
    );

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic idle_cycle();
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        in_valid = 1'b1; in_data = b; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        total++;
        if ({in_ready, wr_en, busy, done, overflow, wr_addr, wr_data, word_count} !== '0) begin
            bad++;
            $display("FAIL reset_big: got rdy=%b wr=%b busy=%b done=%b ovf=%b addr=%h data=%h cnt=%0d want all 0",
                     in_ready, wr_en, busy, done, overflow, wr_addr, wr_data, word_count);
        end
        total++;
        if ({in_ready_s, wr_en_s, busy_s, done_s, overflow_s, wr_addr_s, wr_data_s, word_count_s} !== '0) begin
            bad++;
            $display("FAIL reset_small: got rdy=%b wr=%b busy=%b done=%b want all 0",
                     in_ready_s, wr_en_s, busy_s, done_s);
        end
    endtask

    task automatic test_basic();
        do_start();
        total++;
        if ({busy, in_ready, done, word_count} !== {1'b1, 1'b1, 1'b0, 13'd0}) begin
            bad++;
            $display("FAIL start_state: got busy=%b rdy=%b done=%b cnt=%0d want 1 1 0 0",
                     busy, in_ready, done, word_count);
        end
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), i == 8);
            if (i == 4) begin
                total++;
                if ({wr_en, wr_addr, wr_data, word_count, busy} !== {1'b1, 12'd0, 32'h04030201, 13'd1, 1'b1}) begin
                    bad++;
                    $display("FAIL basic_w0: got wr=%b addr=%0d data=%h cnt=%0d busy=%b want 1 0 04030201 1 1",
                             wr_en, wr_addr, wr_data, word_count, busy);
                end
            end else if (i == 8) begin
                total++;
                if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'd1, 32'h08070605}) begin
                    bad++;
                    $display("FAIL basic_w1: got wr=%b addr=%0d data=%h want 1 1 08070605",
                             wr_en, wr_addr, wr_data);
                end
                total++;
                if ({done, busy, in_ready, overflow, word_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 13'd2}) begin
                    bad++;
                    $display("FAIL basic_done: got done=%b busy=%b rdy=%b ovf=%b cnt=%0d want 1 0 0 0 2",
                             done, busy, in_ready, overflow, word_count);
                end
            end else begin
                total++;
                if (wr_en !== 1'b0 || (i > 4 && {wr_addr, wr_data} !== {12'd0, 32'h04030201})) begin
                    bad++;
                    $display("FAIL basic_nowrite_%0d: got wr=%b addr=%0d data=%h want 0 with held bus",
                             i, wr_en, wr_addr, wr_data);
                end
            end
        end
        // DONE must ignore further offered bytes.
        for (int i = 0; i < 3; i++) send(8'hEE, 1'b1);
        total++;
        if ({wr_en, done, word_count, wr_addr, wr_data} !== {1'b0, 1'b1, 13'd2, 12'd1, 32'h08070605}) begin
            bad++;
            $display("FAIL done_hold: got wr=%b done=%b cnt=%0d addr=%0d data=%h want 0 1 2 1 08070605",
                     wr_en, done, word_count, wr_addr, wr_data);
        end
    endtask

    task automatic test_partial();
        do_start();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        total++;
        if ({wr_en, wr_addr, wr_data, done, word_count} !== {1'b1, 12'd0, 32'h00CCBBAA, 1'b1, 13'd1}) begin
            bad++;
            $display("FAIL partial: got wr=%b addr=%0d data=%h done=%b cnt=%0d want 1 0 00ccbbaa 1 1",
                     wr_en, wr_addr, wr_data, done, word_count);
        end
    endtask

    task automatic test_throttle();
        logic [31:0] exp_data;
        do_start();
        for (int i = 1; i <= 8; i++) begin
            idle_cycle();
            total++;
            if (wr_en !== 1'b0) begin
                bad++;
                $display("FAIL throttle_gap_%0d: got wr=%b want 0", i, wr_en);
            end
            send(8'(i), i == 8);
            total++;
            exp_data = (i <= 4) ? 32'h04030201 : 32'h08070605;
            if (i == 4 || i == 8) begin
                if ({wr_en, wr_addr, wr_data} !== {1'b1, (i == 4) ? 12'd0 : 12'd1, exp_data}) begin
                    bad++;
                    $display("FAIL throttle_w_%0d: got wr=%b addr=%0d data=%h want 1 %0d %h",
                             i, wr_en, wr_addr, wr_data, (i == 4) ? 0 : 1, exp_data);
                end
            end else if (wr_en !== 1'b0) begin
                bad++;
                $display("FAIL throttle_nw_%0d: got wr=%b want 0", i, wr_en);
            end
        end
        total++;
        if ({done, word_count, overflow} !== {1'b1, 13'd2, 1'b0}) begin
            bad++;
            $display("FAIL throttle_done: got done=%b cnt=%0d ovf=%b want 1 2 0", done, word_count, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_data;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_start();
        for (int i = 1; i <= 20; i++) begin
            send(8'(i), 1'b0);
            if (i % 4 == 0 && i <= 16) begin
                exp_data = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
                total++;
                if ({wr_en_s, wr_addr_s, wr_data_s} !== {1'b1, 2'(i / 4 - 1), exp_data}) begin
                    bad++;
                    $display("FAIL ovf_w_%0d: got wr=%b addr=%0d data=%h want 1 %0d %h",
                             i, wr_en_s, wr_addr_s, wr_data_s, i / 4 - 1, exp_data);
                end
            end else if (wr_en_s !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL ovf_extra_%0d: got wr=%b want 0", i, wr_en_s);
            end
            if (i == 16 || i == 20) begin
                total++;
                if ({done_s, overflow_s, word_count_s, in_ready_s, wr_addr_s} !== {1'b1, 1'b1, 3'd4, 1'b0, 2'd3}) begin
                    bad++;
                    $display("FAIL ovf_state_%0d: got done=%b ovf=%b cnt=%0d rdy=%b addr=%0d want 1 1 4 0 3",
                             i, done_s, overflow_s, word_count_s, in_ready_s, wr_addr_s);
                end
            end
        end
    endtask

    task automatic test_abort_rst();
        do_start();
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({in_ready, wr_en, busy, done, overflow, wr_addr, wr_data, word_count} !== '0) begin
            bad++;
            $display("FAIL abort_rst: got rdy=%b wr=%b busy=%b done=%b addr=%0d data=%h cnt=%0d want all 0",
                     in_ready, wr_en, busy, done, wr_addr, wr_data, word_count);
        end
        idle_cycle();
        total++;
        if ({wr_en, busy} !== 2'b00) begin
            bad++;
            $display("FAIL abort_rst_after: got wr=%b busy=%b want 0 0", wr_en, busy);
        end
    endtask

    task automatic test_abort_start();
        do_start();
        for (int i = 1; i <= 6; i++) send(8'(8'h50 + i), 1'b0);
        do_start();
        total++;
        if ({wr_en, word_count, busy} !== {1'b0, 13'd0, 1'b1}) begin
            bad++;
            $display("FAIL restart: got wr=%b cnt=%0d busy=%b want 0 0 1", wr_en, word_count, busy);
        end
        for (int i = 1; i <= 4; i++) send(8'(8'h10 + i), 1'b0);
        total++;
        if ({wr_en, wr_addr, wr_data, word_count} !== {1'b1, 12'd0, 32'h14131211, 13'd1}) begin
            bad++;
            $display("FAIL restart_w0: got wr=%b addr=%0d data=%h cnt=%0d want 1 0 14131211 1",
                     wr_en, wr_addr, wr_data, word_count);
        end
    endtask

    task automatic test_start_wins();
        do_start();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        start = 1'b1; in_valid = 1'b1; in_data = 8'h64; in_last = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        total++;
        if ({wr_en, busy, done, word_count} !== {1'b0, 1'b1, 1'b0, 13'd0}) begin
            bad++;
            $display("FAIL start_wins: got wr=%b busy=%b done=%b cnt=%0d want 0 1 0 0",
                     wr_en, busy, done, word_count);
        end
        send(8'h71, 1'b0);
        send(8'h72, 1'b1);
        total++;
        if ({wr_en, wr_addr, wr_data, done, word_count} !== {1'b1, 12'd0, 32'h00007271, 1'b1, 13'd1}) begin
            bad++;
            $display("FAIL start_wins_w0: got wr=%b addr=%0d data=%h done=%b cnt=%0d want 1 0 00007271 1 1",
                     wr_en, wr_addr, wr_data, done, word_count);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_partial();
        test_throttle();
        test_overflow();
        test_abort_rst();
        test_abort_start();
        test_start_wins();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
